// File: rtl/mem_ctrl_seq.sv
// mem_ctrl_seq: single-issue instruction sequencer driving a memory/control port.
// Optional interrupt support is compiled in with `define MEM_CTRL_SEQ_IRQ_EN.
module mem_ctrl_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        irq,
  output logic [4:0]  addr,
  output logic        wr_en,
  output logic [1:0]  csrc,
  output logic [1:0]  CPC,
  output logic [7:0]  literal,
  output logic        call,
  output logic        ret,
  output logic        push,
  output logic        pop,
  output logic        eint,
  output logic        busy,
  output logic        stack_err,
  output logic [15:0] instr_count
);

  localparam int unsigned DEPTH_W   = 4;
  localparam int unsigned DEPTH_MAX = 10;
  localparam int unsigned CNT_W     = 16;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MOVL  = 3'd1;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_PUSH  = 3'd5;
  localparam logic [2:0] OP_POP   = 3'd6;
  localparam logic [2:0] OP_SKIPZ = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_IRQ  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [2:0]         r_op;
  logic [4:0]         r_addr;
  logic [7:0]         r_lit;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_in_call;
  logic               r_irq_pending;
  logic               r_in_isr;
  logic               r_stack_err;
  logic [CNT_W-1:0]   r_instr_count;
  logic               w_irq_pend;
  logic               w_drop;
  logic               w_handshake;

  // Interrupt request is visible in the same cycle it arrives, masked inside the ISR
`ifdef MEM_CTRL_SEQ_IRQ_EN
  assign w_irq_pend = r_irq_pending | (irq & ~r_in_isr);
`else
  logic w_unused_irq;
  assign w_irq_pend   = 1'b0;
  assign w_unused_irq = ^{irq, r_irq_pending, r_in_isr};
`endif

  // Stack-bounds violation: push when full or pop when empty is discarded
  assign w_drop = ((r_op == OP_PUSH) && (r_depth == DEPTH_W'(DEPTH_MAX))) ||
                  ((r_op == OP_POP)  && (r_depth == DEPTH_W'(0)));

  assign w_handshake = instr_valid & instr_ready;
  assign stack_err   = r_stack_err;
  assign instr_count = r_instr_count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and port decode; reset blanks every strobe in the same cycle
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    busy         = 1'b0;
    addr         = 5'd0;
    wr_en        = 1'b0;
    csrc         = 2'd0;
    CPC          = 2'd0;
    literal      = 8'd0;
    call         = 1'b0;
    ret          = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    eint         = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          instr_ready = ~w_irq_pend;
          if (w_irq_pend)       w_next_state = S_IRQ;
          else if (instr_valid) w_next_state = S_EXEC;
        end
        S_EXEC: begin
          w_next_state = S_IDLE;
          busy         = 1'b1;
          addr         = r_addr;
          literal      = r_lit;
          wr_en        = ~w_drop;
          CPC          = 2'd1;
          case (r_op)
            OP_NOP:   addr = 5'h1F;
            OP_MOVL:  csrc = 2'd1;
            OP_CALL:  begin call = 1'b1; CPC = 2'd0; end
            OP_RET:   begin ret  = 1'b1; CPC = 2'd0; end
            OP_PUSH:  push = ~w_drop;
            OP_POP:   pop  = ~w_drop;
            OP_SKIPZ: CPC  = 2'd2;
            default:  ;
          endcase
        end
        S_IRQ: begin
          w_next_state = S_IDLE;
          busy         = 1'b1;
          wr_en        = 1'b1;
          addr         = 5'h1F;
`ifdef MEM_CTRL_SEQ_IRQ_EN
          eint         = 1'b1;
`endif
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Instruction latch, stack depth, link tracking, error flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op          <= 3'd0;
      r_addr        <= 5'd0;
      r_lit         <= 8'd0;
      r_depth       <= DEPTH_W'(0);
      r_in_call     <= 1'b0;
      r_stack_err   <= 1'b0;
      r_instr_count <= CNT_W'(0);
    end else begin
      if (w_handshake) begin
        r_op   <= instr[15:13];
        r_addr <= instr[12:8];
        r_lit  <= instr[7:0];
      end
      if (r_state == S_EXEC) begin
        if (w_drop) begin
          r_stack_err <= 1'b1;
        end else begin
          r_instr_count <= r_instr_count + CNT_W'(1);
          case (r_op)
            OP_PUSH: r_depth <= r_depth + DEPTH_W'(1);
            OP_POP:  r_depth <= r_depth - DEPTH_W'(1);
            OP_CALL: begin
              if (r_in_call) r_stack_err <= 1'b1;
              r_in_call <= 1'b1;
            end
            OP_RET:  r_in_call <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef MEM_CTRL_SEQ_IRQ_EN
  // Interrupt bookkeeping: latch request, enter ISR after the IRQ cycle, leave on RET
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_pending <= 1'b0;
      r_in_isr      <= 1'b0;
    end else if (r_state == S_IRQ) begin
      r_irq_pending <= 1'b0;
      r_in_isr      <= 1'b1;
    end else begin
      if (irq & ~r_in_isr) r_irq_pending <= 1'b1;
      if ((r_state == S_EXEC) && (r_op == OP_RET)) r_in_isr <= 1'b0;
    end
  end
`else
  // Interrupt state held cleared when the feature is not built
  always_ff @(posedge clk) begin
    r_irq_pending <= 1'b0;
    r_in_isr      <= 1'b0;
  end
`endif

endmodule

// File: doc/mem_ctrl_seq.md
MEM_CTRL_SEQ -- requirements
Module: mem_ctrl_seq

Interface
REQ-001 The block SHALL use: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 The block SHALL use: rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have: instr  input  16  instruction word; op=[15:13], field addr=[12:8], lit=[7:0].
REQ-004 The block SHALL have: instr_valid  input  1  instr is presented.
REQ-005 The block SHALL have: instr_ready  output  1  instruction accepted this cycle when instr_valid & instr_ready.
REQ-006 The block SHALL have: irq  input  1  external interrupt request, level, sampled every cycle.
REQ-007 The block SHALL have the memory-port outputs: addr  5; wr_en  1; csrc  2; CPC  2; literal  8; call  1; ret  1; push  1; pop  1; eint  1.
REQ-008 The block SHALL have: busy  output  1  high outside IDLE.
REQ-009 The block SHALL have: stack_err  output  1  sticky stack overflow/underflow flag.
REQ-010 The block SHALL have: instr_count  output  16  retired-instruction counter.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXEC, IRQ.
- IDLE->IRQ on a pending interrupt; otherwise IDLE->EXEC on handshake.
- EXEC->IDLE and IRQ->IDLE unconditionally after 1 cycle.
REQ-012 instr_ready SHALL equal (state==IDLE) & ~irq_pending, so a pending interrupt has priority over instr_valid in the same cycle.
REQ-013 On handshake the block SHALL latch op, addr and lit; in the following EXEC cycle it SHALL drive addr=field and literal=lit, and pulse wr_en=1 for exactly one cycle.
REQ-014 Op decode in EXEC SHALL be:
- 000 NOP: addr=5'h1F, csrc=00, CPC=1.
- 001 MOVL: csrc=01, CPC=1.
- 010 MOVD: csrc=00, CPC=1.
- 011 CALL: call=1, CPC=0.
- 100 RET: ret=1, CPC=0.
- 101 PUSH: push=1, csrc=00, CPC=1.
- 110 POP: pop=1, csrc=00, CPC=1.
- 111 SKIPZ: csrc=00, CPC=2.
REQ-015 Outside EXEC and IRQ, wr_en, call, ret, push, pop and eint SHALL be 0, and CPC SHALL be 0.
REQ-016 The block SHALL track stack depth 0..10 (4 bits):
- PUSH increments depth; POP decrements it.
- PUSH at depth 10 or POP at depth 0 SHALL be dropped: wr_en, push and pop stay 0, depth is unchanged, and stack_err is set.
- A dropped instruction still returns the FSM to IDLE but does not increment instr_count.
REQ-017 instr_count SHALL increment by 1 at the end of every non-dropped EXEC cycle and SHALL wrap from 16'hFFFF to 0.
REQ-018 CALL while in_call=1 SHALL be executed and SHALL also set stack_err, because the link register is single-level; CALL sets in_call and RET clears it.
REQ-019 RET with in_call=0 SHALL be executed normally without setting an error.
REQ-020 instr SHALL be ignored in EXEC and IRQ, and instr_ready SHALL be 0 in those states.

Reset
REQ-021 When rst=1 at posedge clk, the block SHALL enter IDLE and clear depth, in_call, irq_pending, in_isr, stack_err and instr_count; all strobes, addr, csrc, CPC and literal SHALL be 0.
REQ-022 Reset SHALL override any operation in progress: an EXEC or IRQ cycle coincident with reset SHALL produce no strobe, and the instruction is lost.
REQ-023 After reset deasserts, instr_ready SHALL be 1 on the first cycle.

Configuration
REQ-024 The block SHALL provide macro MEM_CTRL_SEQ_IRQ_EN.
REQ-025 With MEM_CTRL_SEQ_IRQ_EN defined:
- irq=1 while in_isr=0 sets irq_pending.
- From IDLE, IRQ state pulses wr_en=1, eint=1, CPC=0, addr=5'h1F and csrc=00 for one cycle, then sets in_isr and clears irq_pending.
- irq is masked while in_isr=1; in_isr is cleared by the next executed RET.
REQ-026 Without MEM_CTRL_SEQ_IRQ_EN, irq SHALL be ignored, the IRQ state SHALL be unreachable, and eint SHALL be tied to 0.

Verification
REQ-027 Reset, then MOVL instr=16'h2555 (addr=5, lit=55) valid for 1 cycle -> next cycle wr_en=1, addr=5, csrc=01, CPC=1, literal=8'h55; then IDLE; instr_count=1.
REQ-028 Eleven consecutive PUSH -> the first 10 strobe push=1; the 11th has no strobe, stack_err=1 and instr_count=10.
REQ-029 POP immediately after reset -> no strobe and stack_err=1; subsequent MOVL executes normally.
REQ-030 (IRQ_EN) irq=1 and instr_valid=1 in the same IDLE cycle -> instr_ready=0, an IRQ cycle with eint=1 and wr_en=1, then the instruction is accepted; a second irq is ignored until RET.
REQ-031 CALL lit=8'h40, CALL lit=8'h60 -> both execute with call=1 and CPC=0; stack_err=1 after the second.
REQ-032 rst asserted during the EXEC of a MOVL -> that cycle has wr_en=0, instr_count=0 and state=IDLE.
